// File: rtl/ro_pair_compare.sv
// ro_pair_compare
//   Measurement stage of the RO-PUF. For each of RESP_BITS ring-oscillator
//   pairs it selects the pair (ro_sel), waits for a full gate-high window,
//   counts rising edges of both oscillators inside that window, compares the
//   two counts and stores one response bit. The finished word is offered to
//   the key-generation logic with a valid/ack handshake.
//
//   Handshake: resp_valid rises when the word is complete and stays high,
//   with resp stable, until resp_ack is seen high on a clock edge; resp_valid
//   drops on the following cycle. resp_ack while resp_valid is low has no
//   effect. start is a one-cycle request honoured only while idle.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   gate       in   measurement window from the clock divider (async level)
//   ro_a/ro_b  in   oscillators of the selected pair (async)
//   start      in   one-cycle pulse, begins a run (idle only)
//   ro_sel     out  index of the pair under measurement (external RO mux)
//   busy       out  high from accepted start until resp_valid
//   resp       out  response word, bit i = result of pair i
//   resp_valid out  response ready, held until resp_ack
//   resp_ack   in   consumer accepted resp
//   sat        out  sticky per run: an edge counter saturated
//   tie_mask   out  (only with ROPUF_TIE_MASK_EN) bit i = pair i tied or
//                   saturated, so the key logic can discard it
//
// Optional feature macro: ROPUF_TIE_MASK_EN

module ro_pair_compare #(
    parameter int CNT_W     = 16,
    parameter int RESP_BITS = 8,
    parameter int SEL_W     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 gate,
    input  logic                 ro_a,
    input  logic                 ro_b,
    input  logic                 start,
    output logic [SEL_W-1:0]     ro_sel,
    output logic                 busy,
    output logic [RESP_BITS-1:0] resp,
    output logic                 resp_valid,
    input  logic                 resp_ack,
    output logic                 sat
`ifdef ROPUF_TIE_MASK_EN
    ,
    output logic [RESP_BITS-1:0] tie_mask
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(RESP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_COUNT = 3'd2,
        S_CMP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    // Two flops of synchronisation; the third flop is only the edge reference.
    logic [2:0] gate_sh;
    logic [2:0] a_sh;
    logic [2:0] b_sh;

    logic gate_rise;
    logic gate_fall;
    logic a_rise;
    logic b_rise;

    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic             last_pair;

    always_ff @(posedge clk) begin
        if (reset) begin
            gate_sh <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
        end else begin
            gate_sh <= {gate_sh[1:0], gate};
            a_sh    <= {a_sh[1:0], ro_a};
            b_sh    <= {b_sh[1:0], ro_b};
        end
    end

    assign gate_rise = gate_sh[1] & ~gate_sh[2];
    assign gate_fall = ~gate_sh[1] & gate_sh[2];
    assign a_rise    = a_sh[1] & ~a_sh[2];
    assign b_rise    = b_sh[1] & ~b_sh[2];
    assign last_pair = (ro_sel == LAST_SEL);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)     state_d = S_ARM;
            // Only a detected rising edge opens a window, so a gate that is
            // already high when the run starts is skipped until it rises again.
            S_ARM:   if (gate_rise) state_d = S_COUNT;
            S_COUNT: if (gate_fall) state_d = S_CMP;
            S_CMP:   state_d = last_pair ? S_DONE : S_ARM;
            S_DONE:  if (resp_ack)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        busy       = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            S_ARM, S_COUNT, S_CMP: busy       = 1'b1;
            S_DONE:                resp_valid = 1'b1;
            default: begin
                busy       = 1'b0;
                resp_valid = 1'b0;
            end
        endcase
    end

    // Datapath: pair select, edge counters, response assembly
    always_ff @(posedge clk) begin
        if (reset) begin
            ro_sel <= '0;
            resp   <= '0;
            sat    <= 1'b0;
            cnt_a  <= '0;
            cnt_b  <= '0;
`ifdef ROPUF_TIE_MASK_EN
            tie_mask <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        ro_sel <= '0;
                        resp   <= '0;
                        sat    <= 1'b0;
`ifdef ROPUF_TIE_MASK_EN
                        tie_mask <= '0;
`endif
                    end
                end
                S_ARM: begin
                    if (gate_rise) begin
                        cnt_a <= '0;
                        cnt_b <= '0;
                    end
                end
                S_COUNT: begin
                    // Counters stop at all-ones; sat flags the moment one
                    // reaches it and stays set for the rest of the run.
                    if (a_rise && (cnt_a != CNT_MAX)) begin
                        cnt_a <= cnt_a + 1'b1;
                        if (cnt_a == CNT_MAX - 1'b1) sat <= 1'b1;
                    end
                    if (b_rise && (cnt_b != CNT_MAX)) begin
                        cnt_b <= cnt_b + 1'b1;
                        if (cnt_b == CNT_MAX - 1'b1) sat <= 1'b1;
                    end
                end
                S_CMP: begin
                    resp[ro_sel] <= (cnt_a > cnt_b);
`ifdef ROPUF_TIE_MASK_EN
                    // A saturated count no longer reflects frequency, so
                    // treat the pair as unreliable like an exact tie.
                    tie_mask[ro_sel] <= (cnt_a == cnt_b) || (cnt_a == CNT_MAX)
                                        || (cnt_b == CNT_MAX);
`endif
                    // Advancing here keeps the mux change inside gate-low
                    // time, giving the next pair time to settle.
                    if (!last_pair) ro_sel <= ro_sel + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/ro_pair_compare.md
Name: ro_pair_compare

Overview:
- Measurement stage of the RO-PUF: consumes the slow gate clock from the clock divider and generates response bits from ring-oscillator pairs.
- For each of RESP_BITS pairs, it selects the pair, counts rising edges of both oscillators during one gate-high window, compares the counts, and stores one bit.
- It delivers the assembled response word to the key-generation logic through a valid/ack handshake.

Parameters:
CNT_W, 16, edge-counter width per oscillator
RESP_BITS, 8, response bits (RO pairs) per run
SEL_W, 3, pair-select width; RESP_BITS <= 2**SEL_W

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
gate  in  1  measurement window (divider slow output), asynchronous level
ro_a  in  1  oscillator A of the selected pair, asynchronous
ro_b  in  1  oscillator B of the selected pair, asynchronous
start  in  1  one-cycle pulse; begins a run
ro_sel  out  SEL_W  index of the pair under measurement (drives external RO mux)
busy  out  1  high from accepted start until resp_valid
resp  out  RESP_BITS  response word; bit i = result of pair i
resp_valid  out  1  response ready; held until resp_ack
resp_ack  in  1  consumer accepted resp
sat  out  1  sticky per run: a counter saturated

Behaviour:
- One clock domain, one synchronous active-high reset.
- Reset values: ro_sel=0, busy=0, resp=0, resp_valid=0, sat=0. Counters=0, FSM=IDLE, all synchroniser flops=0.
- gate, ro_a and ro_b each pass through a 2-flop synchroniser. A rising or falling edge is detected against a third flop. Each edge pulse is therefore 3 clk after the input transition.
- Counters:
  - During COUNT, each detected ro_a rising edge increments cnt_a; ro_b likewise increments cnt_b.
  - Counters saturate at 2**CNT_W-1. On saturation, sat is set and stays set until the next accepted start.
- FSM states:
  - IDLE: start -> ARM. On entry to ARM: ro_sel=0, resp=0, sat=0, busy=1.
  - ARM: wait for a gate rising edge. On it: cnt_a=cnt_b=0, go to COUNT. A gate that is already high at start is ignored until its next rising edge, so a partial window is never used.
  - COUNT: count while in state. A gate falling edge -> CMP.
  - CMP (1 cycle): resp[ro_sel] <= (cnt_a > cnt_b). A tie gives 0. If ro_sel==RESP_BITS-1, go to DONE; otherwise ro_sel+1 and go to ARM.
  - DONE: resp_valid=1, busy=0. resp_ack -> IDLE, resp_valid=0 the next cycle. resp and ro_sel hold until the next start.
- start is ignored in every state except IDLE, including DONE before the ack.
- resp_ack outside DONE is ignored.
- The ro_sel change in CMP lands before the next gate rising edge. The new pair therefore settles during gate-low time, which is at least half the divider period.
- Reset asserted mid-run aborts immediately to the reset values. No partial response is flagged valid.
- A start pulse in the same cycle as reset is ignored.
- Per run latency: RESP_BITS gate periods, plus up to one extra period for the first rising edge, plus 3-cycle synchroniser delay, plus 1 cycle for DONE.

Optional Feature:
- Macro ROPUF_TIE_MASK_EN.
- Defined: adds output tie_mask [RESP_BITS], reset 0 and cleared on start. In CMP, tie_mask[ro_sel] <= (cnt_a == cnt_b); a saturated pair also counts as a tie. Key logic uses it to discard unreliable bits.
- Undefined: no tie_mask port and no comparator-equality logic; ties silently give 0.

Test Plan:
- Basic run, RESP_BITS=8, gate period 128 clk (64 high):
  - Stimulus: ro_a rises every 4 clk, ro_b every 8 clk, for all pairs.
  - Required: resp=8'hFF, resp_valid after the 8th gate fall, sat=0.
- Pattern:
  - Stimulus: swap the ro_a and ro_b rates on odd ro_sel.
  - Required: resp=8'h55.
- Tie:
  - Stimulus: identical ro_a and ro_b waveforms.
  - Required: resp=8'h00; with ROPUF_TIE_MASK_EN, tie_mask=8'hFF.
- Saturation:
  - Stimulus: CNT_W=4, ro_a rises every 2 clk over a 64-clk window, ro_b every 8 clk.
  - Required: cnt_a stops at 15, sat=1, bit=1 (15>8).
- Handshake and ignored start:
  - Stimulus: pulse start while busy and again in DONE before resp_ack.
  - Required: no restart, resp unchanged. resp_valid holds until the ack, then drops the next cycle. A following start begins a new run.
- Mid-run reset:
  - Stimulus: assert reset during COUNT of pair 3.
  - Required: next cycle busy=0, ro_sel=0, resp=0, resp_valid=0. Gate already high when start is asserted does not open a window until its next rising edge.
